// File: rtl/adc_chan_conditioner.sv
// ---------------------------------------------------------------------------
// adc_chan_conditioner
//
// N-channel ADC front-end conditioner running on the fast ADC sample clock.
// It sits between the IDDR/IDELAY capture and the feedback/DAC datapath.
// For each channel, in order:
//   1. undo board bit inversions with a per-channel XOR mask (BITFLIP)
//   2. measure a pedestal on request (average of 2**PED_LOG2 valid samples)
//   3. subtract the pedestal with saturation to the DW-bit signed range
//   4. optionally flag ADC over-range (sticky)
//
// Optional feature macro: ADC_OVR_DETECT_EN
//   defined   : sticky over-range flags; clr_ovr clears them, and a new set wins
//   undefined : ovr_flags tied to 0, clr_ovr ignored, no compare logic
//
// Parameters
//   N_CH      number of channels
//   DW        sample width (two's complement after the mask)
//   PED_LOG2  pedestal averages 2**PED_LOG2 samples (1..8)
//   BITFLIP   packed per-channel XOR masks, channel 0 in bits [DW-1:0]
//
// Ports
//   clk357      in   ADC sample clock, all logic on its rising edge
//   rst         in   synchronous reset, active-high
//   data_in     in   raw ADC words, channel c at [c*DW +: DW]
//   run         in   sample-valid gate for data_in
//   ped_trig    in   pedestal measurement request (level, sampled in IDLE)
//   clr_ovr     in   clear sticky over-range flags
//   data_out    out  corrected, pedestal-subtracted signed samples
//   data_valid  out  data_out qualifier
//   ped_out     out  current pedestal per channel, signed
//   ped_busy    out  pedestal FSM in ACCUM or UPDATE
//   ped_done    out  1-cycle pulse while the new pedestal is being loaded
//   ovr_flags   out  sticky per-channel over-range flags
//
// Latency from data_in/run to data_out/data_valid is 2 cycles.
// ---------------------------------------------------------------------------
module adc_chan_conditioner #(
  parameter int                 N_CH     = 4,
  parameter int                 DW       = 13,
  parameter int                 PED_LOG2 = 4,
  parameter logic [N_CH*DW-1:0] BITFLIP  = '0
) (
  input  logic                 clk357,
  input  logic                 rst,
  input  logic [N_CH*DW-1:0]   data_in,
  input  logic                 run,
  input  logic                 ped_trig,
  input  logic                 clr_ovr,
  output logic [N_CH*DW-1:0]   data_out,
  output logic                 data_valid,
  output logic [N_CH*DW-1:0]   ped_out,
  output logic                 ped_busy,
  output logic                 ped_done,
  output logic [N_CH-1:0]      ovr_flags
);

  // Accumulator holds the sum of 2**PED_LOG2 DW-bit samples, so it needs
  // PED_LOG2 extra bits and can never overflow.
  localparam int AW = DW + PED_LOG2;

  localparam logic [DW-1:0]       S_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]       S_MIN    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [PED_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2
  } ped_state_e;

  // Signed difference at DW+1 bits, clamped back into the DW-bit range.
  // The two top bits disagree exactly when the result does not fit.
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW:0] diff;
    diff = {a[DW-1], a} - {b[DW-1], b};
    case (diff[DW:DW-1])
      2'b01:   sat_sub = S_MAX;
      2'b10:   sat_sub = S_MIN;
      default: sat_sub = diff[DW-1:0];
    endcase
  endfunction

  // Arithmetic right shift floors toward -inf, which is the rounding we want
  // for the average; the result always fits back into DW bits.
  function automatic logic [DW-1:0] ped_of(input logic [AW-1:0] acc);
    logic signed [AW-1:0] shifted;
    shifted = $signed(acc) >>> PED_LOG2;
    ped_of  = shifted[DW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0][DW-1:0] s1_q,       s1_d;
  logic                    v1_q,       v1_d;
  logic [N_CH-1:0][DW-1:0] data_out_q, data_out_d;
  logic                    valid_q,    valid_d;

  ped_state_e              state_q,    state_d;
  logic [N_CH-1:0][AW-1:0] acc_q,      acc_d;
  logic [PED_LOG2-1:0]     cnt_q,      cnt_d;
  logic [N_CH-1:0][DW-1:0] ped_q,      ped_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;

  // ---------------------------------------------------------------------------
  // Datapath: mask stage then subtract/saturate stage
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    s1_d       = '0;
    data_out_d = '0;
    v1_d       = run;
    valid_d    = v1_q;
    for (int c = 0; c < N_CH; c++) begin
      s1_d[c]       = data_in[c*DW +: DW] ^ BITFLIP[c*DW +: DW];
      // data_out tracks every cycle; data_valid alone says whether it counts.
      data_out_d[c] = sat_sub(s1_q[c], ped_q[c]);
    end
  end

  // ---------------------------------------------------------------------------
  // Pedestal FSM next state. busy/done are computed on the transition so the
  // registered versions line up exactly with the ACCUM/UPDATE states.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ped_trig) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ACCUM: begin
        // Invalid cycles are skipped without advancing the count.
        if (v1_q) begin
          for (int c = 0; c < N_CH; c++) begin
            acc_d[c] = acc_q[c] + {{PED_LOG2{s1_q[c][DW-1]}}, s1_q[c]};
          end
          cnt_d = cnt_q + PED_LOG2'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = UPDATE;
            done_d  = 1'b1;
          end
        end
      end
      UPDATE: begin
        // ped_q changes at the end of this cycle, so subtraction keeps the old
        // pedestal until the cycle after UPDATE. A trigger here is dropped.
        for (int c = 0; c < N_CH; c++) begin
          ped_d[c] = ped_of(acc_q[c]);
        end
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk357) begin
    if (rst) begin
      s1_q       <= '0;
      v1_q       <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ped_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      v1_q       <= v1_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ped_q      <= ped_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign ped_out    = ped_q;
  assign ped_busy   = busy_q;
  assign ped_done   = done_q;

  // ---------------------------------------------------------------------------
  // Over-range detection: a valid mask-corrected sample sitting on either
  // rail means the ADC clipped.
  // ---------------------------------------------------------------------------
`ifdef ADC_OVR_DETECT_EN
  logic [N_CH-1:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = clr_ovr ? '0 : ovr_q;
    // Applied after the clear so a simultaneous set wins.
    for (int c = 0; c < N_CH; c++) begin
      if (v1_q && ((s1_q[c] == S_MAX) || (s1_q[c] == S_MIN))) begin
        ovr_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk357) begin
    if (rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr_flags = ovr_q;
`else
  logic unused_clr_ovr;
  assign unused_clr_ovr = clr_ovr;
  assign ovr_flags      = '0;
`endif

endmodule
